// File: rtl/display_compositor.sv
// Priority compositor for NUM_LAYERS pre-rendered layers plus the frame-synchronised mode FSM and boot progress bar.
// Optional layer-0 alpha blend: define DISPLAY_COMPOSITOR_ALPHA_EN.
module display_compositor #(
  parameter int unsigned             NUM_LAYERS    = 8,
  parameter int unsigned             CW            = 4,
  parameter logic [3*CW-1:0]         BG_COLOR      = 12'h000,
  parameter logic [NUM_LAYERS-1:0]   MASK_PAUSED   = 8'hFF,
  parameter logic [NUM_LAYERS-1:0]   MASK_RUNNING  = 8'hFF,
  parameter logic [NUM_LAYERS-1:0]   MASK_ERROR    = 8'hFE,
  parameter logic [NUM_LAYERS-1:0]   MASK_BOOT     = 8'h00,
  parameter int unsigned             PROG_DIV_BITS = 19,
  parameter int unsigned             PROG_MAX      = 1024,
  parameter int unsigned             PB_Y          = 374,
  parameter int unsigned             PB_H          = 20,
  parameter logic [3*CW-1:0]         PB_COLOR      = 12'hFFF
) (
  input  logic                            clk_65mhz,
  input  logic                            reset_n,
  input  logic [10:0]                     hcount,
  input  logic [9:0]                      vcount,
  input  logic                            at_display_area,
  input  logic [2:0]                      system_status,
  input  logic [NUM_LAYERS*3*CW-1:0]      layer_pixel,
  input  logic [NUM_LAYERS-1:0]           layer_hit,
  output logic [NUM_LAYERS-1:0]           layer_enable,
  output logic [1:0]                      mode,
  output logic                            boot_done,
  output logic [10:0]                     progress_width,
  output logic [CW-1:0]                   r_out,
  output logic [CW-1:0]                   g_out,
  output logic [CW-1:0]                   b_out,
  output logic [$clog2(NUM_LAYERS)-1:0]   hit_index,
  output logic                            hit_valid
);

  localparam int unsigned IW      = $clog2(NUM_LAYERS);
  localparam int unsigned PW      = 3 * CW;
  localparam logic [10:0] PMAX    = 11'(PROG_MAX);
  localparam logic [9:0]  BAR_TOP = 10'(PB_Y);
  localparam logic [9:0]  BAR_END = 10'(PB_Y + PB_H);

  typedef enum logic [1:0] {
    PAUSED  = 2'd0,
    RUNNING = 2'd1,
    ERROR   = 2'd2,
    BOOT    = 2'd3
  } mode_t;

  mode_t                    state_q, state_d, req;
  logic [PROG_DIV_BITS-1:0] presc_q, presc_d;
  logic [10:0]              width_d;
  logic                     frame_start;

  function automatic logic [NUM_LAYERS-1:0] mask_of(input mode_t m);
    case (m)
      PAUSED:  mask_of = MASK_PAUSED;
      RUNNING: mask_of = MASK_RUNNING;
      ERROR:   mask_of = MASK_ERROR;
      default: mask_of = MASK_BOOT;
    endcase
  endfunction

  assign frame_start = (hcount == '0) && (vcount == '0);
  assign req         = mode_t'(system_status[1:0]);

  // Progress advances on the pre-transition mode; a later re-entry into BOOT overrides it with a clear.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    width_d = progress_width;
    if (state_q == BOOT) begin
      presc_d = presc_q + PROG_DIV_BITS'(1);
      if (presc_q == '1 && progress_width != PMAX)
        width_d = progress_width + 11'd1;
    end
    if (frame_start && !system_status[2]) begin
      if (state_q == BOOT) begin
        if (req != BOOT && boot_done)
          state_d = req;
      end else begin
        state_d = req;
        if (req == BOOT) begin
          presc_d = '0;
          width_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_65mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= BOOT;
      presc_q        <= '0;
      progress_width <= '0;
      boot_done      <= 1'b0;
      layer_enable   <= MASK_BOOT;
    end else begin
      state_q        <= state_d;
      presc_q        <= presc_d;
      progress_width <= width_d;
      boot_done      <= (width_d == PMAX);
      layer_enable   <= mask_of(state_d);
    end
  end

  assign mode = state_q;

  logic [NUM_LAYERS*PW-1:0] pix_s1;
  logic [NUM_LAYERS-1:0]    hit_s1;
  logic                     bar_s1, de_s1, bar_c;

  assign bar_c = (state_q == BOOT) && (hcount < progress_width) &&
                 (vcount >= BAR_TOP) && (vcount < BAR_END);

  always_ff @(posedge clk_65mhz or negedge reset_n) begin
    if (!reset_n) begin
      pix_s1 <= '0;
      hit_s1 <= '0;
      bar_s1 <= 1'b0;
      de_s1  <= 1'b0;
    end else begin
      pix_s1 <= layer_pixel;
      hit_s1 <= layer_hit & layer_enable;
      bar_s1 <= bar_c;
      de_s1  <= at_display_area;
    end
  end

  logic [PW-1:0] col_c, win_pix;
  logic [IW-1:0] win_idx;
  logic          found, hv_c;
`ifdef DISPLAY_COMPOSITOR_ALPHA_EN
  logic [PW-1:0] partner, blend;
  logic          pfound;
  logic [CW:0]   sum;
`endif

  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    win_pix = BG_COLOR;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (!found && hit_s1[i]) begin
        found   = 1'b1;
        win_idx = IW'(i);
        win_pix = pix_s1[i*PW +: PW];
      end
    end
`ifdef DISPLAY_COMPOSITOR_ALPHA_EN
    // Partner is the first hit below layer 0; only consulted when layer 0 wins.
    pfound  = 1'b0;
    partner = BG_COLOR;
    for (int unsigned i = 1; i < NUM_LAYERS; i++) begin
      if (!pfound && hit_s1[i]) begin
        pfound  = 1'b1;
        partner = pix_s1[i*PW +: PW];
      end
    end
    blend = '0;
    sum   = '0;
    for (int unsigned c = 0; c < 3; c++) begin
      sum = {1'b0, win_pix[c*CW +: CW]} + {1'b0, partner[c*CW +: CW]};
      blend[c*CW +: CW] = sum[CW:1];
    end
    if (found && win_idx == '0)
      win_pix = blend;
`endif
    col_c = '0;
    hv_c  = 1'b0;
    if (de_s1) begin
      if (bar_s1)
        col_c = PB_COLOR;
      else if (found) begin
        col_c = win_pix;
        hv_c  = 1'b1;
      end else
        col_c = BG_COLOR;
    end
  end

  always_ff @(posedge clk_65mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_out     <= '0;
      g_out     <= '0;
      b_out     <= '0;
      hit_index <= '0;
      hit_valid <= 1'b0;
    end else begin
      r_out     <= col_c[PW-1 -: CW];
      g_out     <= col_c[2*CW-1 -: CW];
      b_out     <= col_c[CW-1:0];
      hit_index <= hv_c ? win_idx : '0;
      hit_valid <= hv_c;
    end
  end

endmodule

// File: tb/tb_display_compositor.sv
// Scoreboard bench for display_compositor: driver predicts from a cycle-count model, monitor pops and compares.
module tb_display_compositor;

  localparam int DIV  = 4;
  localparam int PMAX = 1024;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic        at_display_area = 1'b0;
  logic [2:0]  system_status = '0;
  logic [95:0] layer_pixel = '0;
  logic [7:0]  layer_hit = '0;
  logic [7:0]  layer_enable;
  logic [1:0]  mode;
  logic        boot_done;
  logic [10:0] progress_width;
  logic [3:0]  r_out, g_out, b_out;
  logic [2:0]  hit_index;
  logic        hit_valid;

  display_compositor #(.PROG_DIV_BITS(DIV)) dut (
    .clk_65mhz(clk), .reset_n(reset_n), .hcount(hcount), .vcount(vcount),
    .at_display_area(at_display_area), .system_status(system_status),
    .layer_pixel(layer_pixel), .layer_hit(layer_hit), .layer_enable(layer_enable),
    .mode(mode), .boot_done(boot_done), .progress_width(progress_width),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .hit_index(hit_index), .hit_valid(hit_valid)
  );

  always #8 clk = ~clk;

  typedef struct { int unsigned due; logic [1:0] mode; logic [10:0] w; logic bd; logic [7:0] en; } st_t;
  typedef struct { int unsigned due; logic [11:0] col; logic hv; logic [2:0] idx; } px_t;

  st_t sq[$];
  px_t pq[$];
  int unsigned n_cmp = 0, n_bad = 0, edges = 0, rc = 0;
  bit checking = 0;

  // Model: mode plus number of cycles spent in BOOT since the last clear.
  int unsigned m_mode = 3, m_bc = 0;

  function automatic int unsigned m_width();
    return ((m_bc >> DIV) > PMAX) ? PMAX : (m_bc >> DIV);
  endfunction

  function automatic logic [7:0] mask_for(input int unsigned m);
    case (m)
      0: return 8'hFF;
      1: return 8'hFF;
      2: return 8'hFE;
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Called right after a falling edge: applies inputs and predicts the response.
  task automatic drive(input logic [10:0] h, input logic [9:0] v, input logic de,
                       input logic [2:0] st, input logic [7:0] hit, input logic [95:0] pk);
    int unsigned w, win, nxt;
    bit          bd, bar, have_win, have_nxt;
    logic [7:0]  en, eff;
    logic [11:0] col, other;
    px_t p;
    st_t s;
    w  = m_width();
    bd = (w == PMAX);
    en = mask_for(m_mode);
    hcount = h; vcount = v; at_display_area = de; system_status = st;
    layer_hit = hit; layer_pixel = pk;

    bar = (m_mode == 3) && (h < w) && (v >= 374) && (v < 394);
    eff = hit & en;
    p.due = edges + 2; p.col = 12'h000; p.hv = 1'b0; p.idx = 3'd0;
    if (de) begin
      if (bar) p.col = 12'hFFF;
      else if (eff != 0) begin
        have_win = 0; have_nxt = 0; win = 0; nxt = 0;
        for (int i = 0; i < 8; i++)
          if (eff[i]) begin
            if (!have_win) begin have_win = 1; win = i; end
            else if (!have_nxt) begin have_nxt = 1; nxt = i; end
          end
        col = pk[win*12 +: 12];
`ifdef DISPLAY_COMPOSITOR_ALPHA_EN
        if (win == 0) begin
          other = have_nxt ? pk[nxt*12 +: 12] : 12'h000;
          for (int c = 0; c < 3; c++)
            col[c*4 +: 4] = 4'((int'(col[c*4 +: 4]) + int'(other[c*4 +: 4])) / 2);
        end
`else
        other = 12'h000;
`endif
        p.col = col; p.hv = 1'b1; p.idx = 3'(win);
      end
    end
    pq.push_back(p);

    if (m_mode == 3) m_bc++;
    if (h == 0 && v == 0 && st < 4) begin
      if (m_mode == 3) begin
        if (st != 3 && bd) m_mode = st;
      end else begin
        if (st == 3) m_bc = 0;
        m_mode = st;
      end
    end
    s.due = edges + 1; s.mode = 2'(m_mode); s.w = 11'(m_width());
    s.bd = (m_width() == PMAX); s.en = mask_for(m_mode);
    sq.push_back(s);
  endtask

  task automatic step(input logic [10:0] h, input logic [9:0] v, input logic de,
                      input logic [2:0] st, input logic [7:0] hit, input logic [95:0] pk);
    @(negedge clk);
    drive(h, v, de, st, hit, pk);
  endtask

  task automatic rstep(input logic [2:0] st, input int unsigned period);
    logic [10:0] h;
    logic [9:0]  v;
    logic [95:0] pk;
    rc++;
    if (rc % period == 0) begin
      h = '0; v = '0;
    end else begin
      h = $urandom_range(0, 1) ? 11'($urandom_range(0, m_width() + 4)) : 11'($urandom_range(0, 1343));
      v = $urandom_range(0, 1) ? 10'($urandom_range(370, 398)) : 10'($urandom_range(0, 767));
      if (h == 0 && v == 0) h = 11'd1;
    end
    for (int i = 0; i < 3; i++) pk[i*32 +: 32] = $urandom;
    step(h, v, $urandom_range(0, 7) != 0, st, 8'($urandom) & 8'($urandom), pk);
  endtask

  task automatic check_rgb(input string nm, input logic [11:0] exp, input logic ev, input logic [2:0] ei);
    @(posedge clk); #1;
    chk({nm, "_rgb"}, 32'({r_out, g_out, b_out}), 32'(exp));
    chk({nm, "_valid"}, 32'(hit_valid), 32'(ev));
    chk({nm, "_index"}, 32'(hit_index), 32'(ei));
  endtask

  // Monitor: every output cycle is popped against the queued prediction.
  initial begin
    st_t s;
    px_t p;
    forever begin
      @(posedge clk);
      edges++;
      #1;
      if (checking) begin
        while (sq.size() != 0 && sq[0].due <= edges) begin
          s = sq.pop_front();
          chk("mode", 32'(mode), 32'(s.mode));
          chk("progress_width", 32'(progress_width), 32'(s.w));
          chk("boot_done", 32'(boot_done), 32'(s.bd));
          chk("layer_enable", 32'(layer_enable), 32'(s.en));
        end
        while (pq.size() != 0 && pq[0].due <= edges) begin
          p = pq.pop_front();
          chk("pixel_rgb", 32'({r_out, g_out, b_out}), 32'(p.col));
          chk("hit_valid", 32'(hit_valid), 32'(p.hv));
          chk("hit_index", 32'(hit_index), 32'(p.idx));
        end
      end
    end
  end

  initial begin
    logic [95:0] pk;
    logic [2:0]  st;
    #20;
    chk("rst_mode", 32'(mode), 32'd3);
    chk("rst_width", 32'(progress_width), 32'd0);
    chk("rst_boot_done", 32'(boot_done), 32'd0);
    chk("rst_enable", 32'(layer_enable), 32'h00);
    chk("rst_rgb", 32'({r_out, g_out, b_out}), 32'd0);
    chk("rst_valid", 32'(hit_valid), 32'd0);
    chk("rst_index", 32'(hit_index), 32'd0);

    @(negedge clk);
    reset_n = 1'b1;
    checking = 1;
    drive(11'd1, 10'd1, 1'b0, 3'd1, 8'h00, '0);

    // Boot with RUNNING requested: must exit only once the bar is full.
    for (int i = 0; i < 20000 && m_mode != 1; i++) rstep(3'd1, 64);
    repeat (4) rstep(3'd1, 1000);
    chk("boot_exit_mode", 32'(mode), 32'd1);
    chk("boot_exit_done", 32'(boot_done), 32'd1);
    chk("boot_exit_width", 32'(progress_width), 32'd1024);

    pk = '0;
    pk[2*12 +: 12] = 12'h0F0;
    pk[5*12 +: 12] = 12'hF00;
    step(11'd5, 10'd10, 1'b1, 3'd1, 8'b0010_0100, pk);
    step(11'd6, 10'd10, 1'b0, 3'd1, 8'h00, '0);
    check_rgb("l2_over_l5", 12'h0F0, 1'b1, 3'd2);

    pk = '0;
    pk[0 +: 12]    = 12'hF00;
    pk[3*12 +: 12] = 12'h0F0;
    step(11'd7, 10'd10, 1'b1, 3'd1, 8'b0000_1001, pk);
    step(11'd8, 10'd10, 1'b0, 3'd1, 8'h00, '0);
`ifdef DISPLAY_COMPOSITOR_ALPHA_EN
    check_rgb("l0_over_l3", 12'h770, 1'b1, 3'd0);
`else
    check_rgb("l0_over_l3", 12'hF00, 1'b1, 3'd0);
`endif

    step(11'd9, 10'd10, 1'b0, 3'd1, 8'hFF, {8{12'hABC}});
    step(11'd10, 10'd10, 1'b0, 3'd1, 8'h00, '0);
    check_rgb("blanked", 12'h000, 1'b0, 3'd0);

    step(11'd0, 10'd0, 1'b1, 3'd7, 8'h00, '0);
    step(11'd500, 10'd100, 1'b1, 3'd2, 8'h00, '0);
    step(11'd501, 10'd100, 1'b1, 3'd2, 8'h00, '0);
    chk("status7_ignored", 32'(mode), 32'd1);
    step(11'd0, 10'd0, 1'b1, 3'd2, 8'h00, '0);
    step(11'd1, 10'd0, 1'b1, 3'd2, 8'b0000_1001, pk);
    chk("error_mode", 32'(mode), 32'd2);
    step(11'd2, 10'd0, 1'b1, 3'd2, 8'h00, '0);
    check_rgb("error_masks_l0", 12'h0F0, 1'b1, 3'd3);

    // Random mode requests, excluding BOOT.
    for (int i = 0; i < 2000; i++) begin
      st = 3'($urandom_range(0, 7));
      if (st == 3'd3) st = 3'd1;
      rstep(st, 40);
    end

    // Re-enter BOOT: bar restarts from zero.
    for (int i = 0; i < 2500; i++) rstep(3'd3, 50);
    chk("reboot_mode", 32'(mode), 32'd3);

    @(negedge clk);
    checking = 0;
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst_mode", 32'(mode), 32'd3);
    chk("async_rst_width", 32'(progress_width), 32'd0);
    chk("async_rst_boot_done", 32'(boot_done), 32'd0);
    chk("async_rst_enable", 32'(layer_enable), 32'h00);
    chk("async_rst_rgb", 32'({r_out, g_out, b_out}), 32'd0);
    chk("async_rst_valid", 32'(hit_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
